// File: rtl/eth_pcs_tx_gearbox_gen.sv
// eth_pcs_tx_gearbox_gen
// 64b/66b TX gearbox. It packs 2-bit sync headers and W_DATA-bit scrambled
// payload chunks into a continuous stream of W_DATA-bit PMA words. Every
// block adds two extra header bits. The leftover count therefore grows by 2
// per block, and one stall cycle every PERIOD cycles drains the accumulated
// word. A bypass mode forwards i_scr_data unchanged. The period counter
// keeps running in bypass so that a return to gearbox mode stays aligned.
//
// Ports:
//   i_clk        PMA-side clock
//   i_reset      asynchronous active-low reset
//   i_bypass     1 = raw passthrough, 0 = gearbox (sampled at period wrap)
//   i_valid      upstream chunk valid
//   i_sync_data  sync header, used on chunk 0 of a block
//   i_scr_data   scrambled payload chunk, bit 0 first
//   o_ready      chunk accepted this cycle when i_valid is also high
//   o_trans_cnt  index of the chunk expected next
//   o_pma_data   registered PMA word, bit 0 first
//   o_underflow  sticky: a ready slot had no valid chunk
//   i_clr_err    synchronous clear of o_underflow (set wins)
module eth_pcs_tx_gearbox_gen #(
    parameter int  W_DATA  = 32,
    parameter int  W_SYNC  = 2,
    parameter int  W_BLK   = 64,
    localparam int N_CHUNK = W_BLK / W_DATA,
    localparam int PERIOD  = (W_DATA / W_SYNC) * N_CHUNK + 1,
    localparam int W_TC    = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_bypass,
    input  logic              i_valid,
    input  logic [W_SYNC-1:0] i_sync_data,
    input  logic [W_DATA-1:0] i_scr_data,
    output logic              o_ready,
    output logic [W_TC-1:0]   o_trans_cnt,
    output logic [W_DATA-1:0] o_pma_data,
    output logic              o_underflow,
    input  logic              i_clr_err
);

    localparam int W_BUF = 2 * W_DATA + W_SYNC;
    localparam int W_CNT = $clog2(PERIOD);
    localparam int W_L   = $clog2(W_DATA + 1);
    localparam int W_SLOT = W_DATA + W_SYNC;
    localparam logic [W_CNT-1:0] STALL = W_CNT'(PERIOD - 1);

    logic [W_CNT-1:0]  cnt;
    logic              mode;     // 1 = bypass
    logic [W_BUF-1:0]  buf_q;    // leftover bits, valid in [lcnt-1:0], zero above
    logic [W_L-1:0]    lcnt;
    logic [W_TC-1:0]   tc;
    logic [W_TC-1:0]   tc_next;
    logic              stall;
    logic [W_SLOT-1:0] slot;
    logic [W_BUF-1:0]  merged;

    assign stall       = (cnt == STALL);
    assign o_ready     = i_reset & (mode | ~stall);
    assign o_trans_cnt = tc;
    assign tc_next     = (tc == W_TC'(N_CHUNK - 1)) ? '0 : tc + 1'b1;

    // A missing chunk becomes an all-zero slot of the same width, so the
    // bit count and the block alignment stay intact.
    always_comb begin
        slot = '0;
        if (i_valid) begin
            if (tc == '0)
                slot = {i_scr_data, i_sync_data};
            else
                slot = {{W_SYNC{1'b0}}, i_scr_data};
        end
        merged = buf_q | ({{W_DATA{1'b0}}, slot} << lcnt);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt         <= '0;
            mode        <= i_bypass;
            buf_q       <= '0;
            lcnt        <= '0;
            tc          <= '0;
            o_pma_data  <= '0;
            o_underflow <= 1'b0;
        end else begin
            cnt <= stall ? '0 : cnt + 1'b1;
            if (stall)
                mode <= i_bypass;

            if (o_ready && !i_valid)
                o_underflow <= 1'b1;
            else if (i_clr_err)
                o_underflow <= 1'b0;

            if (mode) begin
                o_pma_data <= i_valid ? i_scr_data : '0;
                tc         <= tc_next;
                buf_q      <= '0;
                lcnt       <= '0;
            end else if (stall) begin
                // lcnt == W_DATA here: drain exactly one full word.
                o_pma_data <= buf_q[W_DATA-1:0];
                buf_q      <= '0;
                lcnt       <= '0;
            end else begin
                o_pma_data <= merged[W_DATA-1:0];
                buf_q      <= merged >> W_DATA;
                if (tc == '0)
                    lcnt <= lcnt + W_L'(W_SYNC);
                tc <= tc_next;
            end

            // Returning to gearbox mode starts a fresh block at chunk 0.
            if (stall && mode && !i_bypass) begin
                tc    <= '0;
                lcnt  <= '0;
                buf_q <= '0;
            end
        end
    end

endmodule
